// File: rtl/ts_stub_cnt_writer.sv
`default_nettype none
// ts_stub_cnt_writer: per-crossing inner/outer stub counter feeding the stub-count FIFO.
// Optional macro TS_STUB_CNT_SKIP_EMPTY_EN suppresses writes of {0,0} crossings. Rev 1.0
module ts_stub_cnt_writer #(
  parameter int CNT_W = 6
) (
  input  logic               clk,
  input  logic               res,
  input  logic               stub_vld,
  input  logic               stub_outer,
  input  logic               bx_end,
  input  logic               fifo_full,
  output logic               fifo_wr_en,
  output logic [2*CNT_W-1:0] fifo_din,
  output logic               cnt_sat,
  output logic               cnt_ovf
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    PEND  = 1'b1
  } state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   inner_cnt, outer_cnt;
  logic [CNT_W-1:0]   inner_fin, outer_fin;
  logic [2*CNT_W-1:0] pend;
  logic               inner_hit, outer_hit;
  logic               sat_hit;
  logic               accept;
  logic               wr;
  logic               load_pend;
  logic               ovf_set;

  assign inner_hit = stub_vld & ~stub_outer;
  assign outer_hit = stub_vld &  stub_outer;

  // Final counts include a stub arriving in the bx_end cycle itself.
  always_comb begin
    inner_fin = inner_cnt;
    outer_fin = outer_cnt;
    sat_hit   = 1'b0;
    if (inner_hit) begin
      if (&inner_cnt) sat_hit = 1'b1;
      else            inner_fin = inner_cnt + CNT_ONE;
    end
    if (outer_hit) begin
      if (&outer_cnt) sat_hit = 1'b1;
      else            outer_fin = outer_cnt + CNT_ONE;
    end
  end

`ifdef TS_STUB_CNT_SKIP_EMPTY_EN
  assign accept = bx_end & ((inner_fin != '0) | (outer_fin != '0));
`else
  assign accept = bx_end;
`endif

  assign wr         = (state == PEND) & ~fifo_full;
  assign fifo_wr_en = wr;
  assign fifo_din   = pend;

  always_comb begin
    state_nxt = state;
    load_pend = 1'b0;
    ovf_set   = 1'b0;
    case (state)
      ACCUM: begin
        if (accept) begin
          load_pend = 1'b1;
          state_nxt = PEND;
        end
      end
      PEND: begin
        if (wr) begin
          if (accept) load_pend = 1'b1;
          else        state_nxt = ACCUM;
        end else if (accept) begin
          // Pending word still unwritten: the new crossing is lost.
          ovf_set = 1'b1;
        end
      end
      default: state_nxt = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (res) begin
      state     <= ACCUM;
      inner_cnt <= '0;
      outer_cnt <= '0;
      pend      <= '0;
      cnt_sat   <= 1'b0;
      cnt_ovf   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (bx_end) begin
        inner_cnt <= '0;
        outer_cnt <= '0;
      end else begin
        inner_cnt <= inner_fin;
        outer_cnt <= outer_fin;
      end
      if (load_pend) pend <= {outer_fin, inner_fin};
      if (sat_hit)   cnt_sat <= 1'b1;
      if (ovf_set)   cnt_ovf <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: doc/ts_stub_cnt_writer.md
# ts_stub_cnt_writer

Write side of the stub-count FIFO that the start-new-crossing state machine reads. Counts stubs per seeding layer (inner/outer) as they stream in during a bunch crossing. At the end-of-crossing strobe, packs the two counts into one word and writes it to the stub-count FIFO. Sits between the stub receive logic and the stub-count FIFO, and handles FIFO back-pressure with a one-word pending register.

## Interface
Parameters:
- CNT_W, 6: width of each per-layer stub counter; each counter saturates at 2^CNT_W-1.

Ports:
- clk  input  1  pipeline clock; all logic on rising edge.
- res  input  1  reset; synchronous, active-high.
- stub_vld  input  1  a stub is present this cycle.
- stub_outer  input  1  layer of the stub: 0 = inner, 1 = outer. Ignored when stub_vld=0.
- bx_end  input  1  single-cycle strobe marking the last cycle of the current crossing.
- fifo_full  input  1  stub-count FIFO cannot accept a write this cycle.
- fifo_wr_en  output  1  write strobe to the stub-count FIFO.
- fifo_din  output  2*CNT_W  {outer_cnt, inner_cnt}; valid whenever fifo_wr_en=1.
- cnt_sat  output  1  sticky flag: a counter saturated.
- cnt_ovf  output  1  sticky flag: a crossing was dropped because the pending register was still occupied.

## Operation
- Counters: inner_cnt and outer_cnt, each CNT_W bits.
  - A stub_vld cycle increments the selected counter.
  - At 2^CNT_W-1 the counter holds its value and sets cnt_sat.
- Same-cycle rule: a stub with stub_vld=1 in the bx_end cycle counts toward the crossing that is ending.
- bx_end cycle:
  - The final counts, including any same-cycle stub, are latched into the pending register `pend`.
  - Both counters are cleared to 0, so the next crossing starts from 0 in the following cycle.
- State machine (states ACCUM, PEND):
  - ACCUM: no pending word.
    - On bx_end: load `pend`, go to PEND.
    - Otherwise stay in ACCUM.
  - PEND: fifo_wr_en = !fifo_full. Counting continues normally.
    - Write this cycle and no bx_end: go to ACCUM.
    - Write this cycle and bx_end: reload `pend` with the new crossing, stay in PEND.
    - fifo_full and no bx_end: stay in PEND; `pend` is held.
    - fifo_full and bx_end: the new crossing is dropped; set cnt_ovf, clear the counters, keep the old `pend`, stay in PEND.
- fifo_din is driven directly by `pend`.
- The sticky flags (cnt_sat, cnt_ovf) are cleared only by res.
- Reset:
  - Goes to ACCUM and clears counters, `pend`, cnt_sat and cnt_ovf.
  - A reset asserted mid-crossing or while in PEND discards all in-flight counts; no write is issued.

## Timing
- Reset values: fifo_wr_en=0, fifo_din=0, cnt_sat=0, cnt_ovf=0, state ACCUM.
- Write latency: bx_end in cycle N gives fifo_wr_en=1 in cycle N+1 if fifo_full=0 in N+1.
- fifo_wr_en is combinational: (state==PEND) & !fifo_full.
  - The FIFO samples din and wr_en on the same edge.
  - fifo_wr_en is never asserted while fifo_full=1.
- Exactly one FIFO write per accepted crossing.
- Minimum crossing length is 1 cycle: back-to-back bx_end strobes are sustainable while fifo_full=0.
- cnt_sat and cnt_ovf assert on the edge that ends the offending cycle; they are visible in the next cycle.

## Configuration
- Macro: TS_STUB_CNT_SKIP_EMPTY_EN.
- Defined: a crossing whose final counts are inner=0 and outer=0 is not written. At that bx_end:
  - `pend` and the state are unchanged.
  - The counters are cleared as usual.
  - An empty crossing never sets cnt_ovf.
- Undefined: every crossing is written, including {0,0}.

## Test plan
- Basic write, fifo_full=0: 3 inner and 2 outer stubs, then bx_end → one cycle later fifo_wr_en=1, fifo_din={2,3}; fifo_wr_en=0 afterwards.
- Same-cycle stub: an outer stub with stub_vld=1 in the bx_end cycle, preceded by 1 outer stub → fifo_din={2,0}. The next crossing starts at 0, shown by 1 inner stub then bx_end → {0,1}.
- Back-pressure: fifo_full=1 for 5 cycles after bx_end with counts {4,1} → fifo_wr_en stays 0. On the first cycle with fifo_full=0: one write, fifo_din={4,1}, cnt_ovf=0.
- Drop: hold fifo_full=1 while a second bx_end with counts {7,7} arrives → cnt_ovf=1. After fifo_full drops, exactly one write of the first word; {7,7} is never written.
- Saturation (CNT_W=3): 10 inner stubs, then bx_end → fifo_din={0,7}, cnt_sat=1 and it remains 1 until res.
- Empty crossing and reset: bx_end with no stubs → a {0,0} write without the macro, no write with TS_STUB_CNT_SKIP_EMPTY_EN. Separately, assert res while in PEND with fifo_full=1 → no write, and all outputs return to 0.
